// File: rtl/score_display_mux.sv
// score_display_mux: shows a 0..10 score as two multiplexed digits on a 4-digit common-anode seven-segment display
// Ports: CLK clock; RESET synchronous active-high reset; SCORE 4-bit binary score;
//        SEG_SELECT active-low anodes (bit0 = rightmost); HEX_OUT active-low segments (bit7 = dp);
//        STROBE_COUNTER current digit slot.
// Option: define WIN_BLINK_EN to blink the display while the score equals MAX_SCORE.
module score_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 25000000,
    parameter int MAX_SCORE   = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] SCORE,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] HEX_OUT,
    output logic [1:0] STROBE_COUNTER
);
    localparam int PW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
    if (REFRESH_DIV < 1 || BLINK_DIV < 1) begin : g_bad_param
        $error("score_display_mux: REFRESH_DIV and BLINK_DIV must be >= 1");
    end
    logic [3:0]    score_q;
    logic [PW-1:0] presc;
    logic          err, tens, show;
    logic [3:0]    ones, sel_d;
    logic [7:0]    ones_code, tens_code, hex_d;
    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 8'hC0;
            4'd1: seg7 = 8'hF9;
            4'd2: seg7 = 8'hA4;
            4'd3: seg7 = 8'hB0;
            4'd4: seg7 = 8'h99;
            4'd5: seg7 = 8'h92;
            4'd6: seg7 = 8'h82;
            4'd7: seg7 = 8'hF8;
            4'd8: seg7 = 8'h80;
            4'd9: seg7 = 8'h90;
            default: seg7 = 8'hFF;
        endcase
    endfunction
    assign err       = int'(score_q) > MAX_SCORE;
    assign tens      = score_q >= 4'd10;
    assign ones      = tens ? score_q - 4'd10 : score_q;
    assign ones_code = err ? 8'hBF : seg7(ones);
    // leading zero on the tens digit is blanked
    assign tens_code = err ? 8'hBF : tens ? seg7(4'd1) : 8'hFF;
`ifdef WIN_BLINK_EN
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
    logic [BW-1:0] bcnt;
    logic          blink_on;
    // leaving the max score restarts the episode in the ON phase
    always_ff @(posedge CLK) begin
        if (RESET || int'(score_q) != MAX_SCORE) begin
            bcnt     <= '0;
            blink_on <= 1'b1;
        end else if (bcnt == B_LAST) begin
            bcnt     <= '0;
            blink_on <= ~blink_on;
        end else begin
            bcnt <= bcnt + 1'b1;
        end
    end
    assign show = blink_on;
`else
    assign show = 1'b1;
`endif
    always_comb begin
        sel_d = !show ? 4'b1111 : STROBE_COUNTER == 2'd0 ? 4'b1110 : STROBE_COUNTER == 2'd1 ? 4'b1101 : 4'b1111;
        hex_d = !show ? 8'hFF : STROBE_COUNTER == 2'd0 ? ones_code : STROBE_COUNTER == 2'd1 ? tens_code : 8'hFF;
    end
    // anodes and segments share one register so they always switch together
    always_ff @(posedge CLK) begin
        if (RESET) begin
            score_q        <= '0;
            presc          <= '0;
            STROBE_COUNTER <= '0;
            SEG_SELECT     <= 4'b1111;
            HEX_OUT        <= 8'hFF;
        end else begin
            score_q        <= SCORE;
            presc          <= presc == P_LAST ? '0 : presc + 1'b1;
            STROBE_COUNTER <= presc == P_LAST ? STROBE_COUNTER + 1'b1 : STROBE_COUNTER;
            SEG_SELECT     <= sel_d;
            HEX_OUT        <= hex_d;
        end
    end
endmodule

// File: tb/tb_score_display_mux.sv
// tb_score_display_mux: directed scoreboard bench for score_display_mux (REFRESH_DIV=4, BLINK_DIV=16)
module tb_score_display_mux;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] SCORE = 4'd0;
    logic [3:0] SEG_SELECT;
    logic [7:0] HEX_OUT;
    logic [1:0] STROBE_COUNTER;

    always #5 CLK = ~CLK;

    score_display_mux #(.REFRESH_DIV(4), .BLINK_DIV(16), .MAX_SCORE(10)) dut (
        .CLK(CLK), .RESET(RESET), .SCORE(SCORE),
        .SEG_SELECT(SEG_SELECT), .HEX_OUT(HEX_OUT), .STROBE_COUNTER(STROBE_COUNTER)
    );

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] sel;
        logic [7:0] hex;
    } exp_t;

    exp_t sb[$];
    int n_chk = 0;
    int n_pass = 0;
    int m_sq = 0, m_presc = 0, m_st = 0, m_bcnt = 0;
    logic m_bon = 1'b1;
    logic [3:0] m_sel = 4'hF;
    logic [7:0] m_hex = 8'hFF;
    logic [7:0] codes [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // one clock: drive inputs, advance the reference model, compare at the falling edge
    task automatic cyc(input logic r, input logic [3:0] s);
        logic [7:0] d0, d1;
        exp_t e;
        RESET = r;
        SCORE = s;
        @(posedge CLK);
        if (r) begin
            m_sq = 0; m_presc = 0; m_st = 0; m_bcnt = 0; m_bon = 1'b1;
            m_sel = 4'hF; m_hex = 8'hFF;
        end else begin
            if (m_sq > 10) begin
                d0 = 8'hBF; d1 = 8'hBF;
            end else begin
                d0 = codes[m_sq % 10];
                d1 = (m_sq / 10 != 0) ? codes[1] : 8'hFF;
            end
            case (m_st)
                0: begin m_sel = 4'b1110; m_hex = d0; end
                1: begin m_sel = 4'b1101; m_hex = d1; end
                default: begin m_sel = 4'b1111; m_hex = 8'hFF; end
            endcase
`ifdef WIN_BLINK_EN
            if (!m_bon) begin m_sel = 4'b1111; m_hex = 8'hFF; end
            if (m_sq == 10) begin
                if (m_bcnt == 15) begin m_bcnt = 0; m_bon = !m_bon; end
                else m_bcnt++;
            end else begin
                m_bcnt = 0; m_bon = 1'b1;
            end
`endif
            m_sq = int'(s);
            if (m_presc == 3) begin m_presc = 0; m_st = (m_st + 1) % 4; end
            else m_presc++;
        end
        sb.push_back('{st: 2'(m_st), sel: m_sel, hex: m_hex});
        @(negedge CLK);
        e = sb.pop_front();
        chk("strobe", 16'(STROBE_COUNTER), 16'(e.st));
        chk("seg_select", 16'(SEG_SELECT), 16'(e.sel));
        chk("hex_out", 16'(HEX_OUT), 16'(e.hex));
    endtask

    // advance until the model reaches a slot/prescaler position (st<0: any) and optionally the OFF phase
    task automatic run_to(input int st, input int presc, input logic [3:0] s, input bit off, input string tag);
        int n = 0;
        while (!((st < 0 || (m_st == st && m_presc == presc)) && (!off || !m_bon)) && n < 200) begin
            cyc(1'b0, s);
            n++;
        end
        n_chk++;
        assert (n < 200) n_pass++;
        else $error("FAIL %s: wait took %0d cycles, limit 200", tag, n);
    endtask

    initial begin
        cyc(1'b1, 4'd0);
        cyc(1'b1, 4'd0);
        chk("reset_strobe", 16'(STROBE_COUNTER), 16'd0);
        chk("reset_sel", 16'(SEG_SELECT), 16'hF);
        chk("reset_hex", 16'(HEX_OUT), 16'hFF);
        cyc(1'b0, 4'd0);
        chk("first_sel", 16'(SEG_SELECT), 16'hE);
        chk("first_hex", 16'(HEX_OUT), 16'hC0);
        repeat (19) cyc(1'b0, 4'd0);
        repeat (16) cyc(1'b0, 4'd7);
        run_to(0, 1, 4'd7, 1'b0, "mid_slot0");
        cyc(1'b0, 4'd3);
        chk("mid_old_hex", 16'(HEX_OUT), 16'hF8);
        cyc(1'b0, 4'd3);
        chk("mid_new_hex", 16'(HEX_OUT), 16'hB0);
        repeat (14) cyc(1'b0, 4'd3);
        repeat (120) cyc(1'b0, 4'd10);
        repeat (16) cyc(1'b0, 4'd12);
        repeat (16) cyc(1'b0, 4'd15);
`ifdef WIN_BLINK_EN
        repeat (20) cyc(1'b0, 4'd10);
        run_to(-1, 0, 4'd10, 1'b1, "blink_off");
        repeat (3) cyc(1'b0, 4'd9);
        repeat (40) cyc(1'b0, 4'd10);
        run_to(1, 1, 4'd10, 1'b1, "reset_slot1");
`else
        run_to(1, 1, 4'd10, 1'b0, "reset_slot1");
`endif
        cyc(1'b1, 4'd10);
        chk("midrst_strobe", 16'(STROBE_COUNTER), 16'd0);
        chk("midrst_sel", 16'(SEG_SELECT), 16'hF);
        chk("midrst_hex", 16'(HEX_OUT), 16'hFF);
        repeat (3) cyc(1'b0, 4'd10);
        chk("restart_hold", 16'(STROBE_COUNTER), 16'd0);
        cyc(1'b0, 4'd10);
        chk("restart_step", 16'(STROBE_COUNTER), 16'd1);
        repeat (20) cyc(1'b0, 4'd10);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
